// File: rtl/fastica_error_unit_if.sv
// rtl/fastica_error_unit_if.sv - controller/weight-store bus of the FastICA convergence checker
interface fastica_error_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 34
) ();
    logic              en_error;
    logic              error_busy;
    logic              isConverge;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] w_new_data;
    logic [DATA_W-1:0] w_old_data;
    logic              old_wr_en;
    logic [ADDR_W-1:0] old_wr_addr;
    logic [DATA_W-1:0] old_wr_data;
    logic [ACC_W-1:0]  err_max;

    modport slave (
        input  en_error, w_new_data, w_old_data,
        output error_busy, isConverge, rd_en, rd_addr,
               old_wr_en, old_wr_addr, old_wr_data, err_max
    );

    modport master (
        output en_error, w_new_data, w_old_data,
        input  error_busy, isConverge, rd_en, rd_addr,
               old_wr_en, old_wr_addr, old_wr_data, err_max
    );
endinterface

// File: rtl/fastica_error_unit.sv
// rtl/fastica_error_unit.sv - per-row |1-|w_new.w_old|| convergence check with w_old refresh
module fastica_error_unit #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int FRAC   = 14,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 34,
    parameter int EPS    = 268
) (
    input  logic                 clk_error,
    input  logic                 rstn,
    fastica_error_unit_if.slave  bus
);
    localparam int COL_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(N * N - 1);
    localparam logic [COL_W-1:0]        LAST_COL  = COL_W'(N - 1);
    localparam logic signed [ACC_W-1:0] ONE       = ACC_W'(1) << (2 * FRAC);
    localparam logic [ACC_W-1:0]        EPS_V     = ACC_W'(EPS);

    typedef enum logic [1:0] {IDLE, COMPARE, DRAIN, DONE} state_t;

    state_t state, next_state;

    logic                     en_prev;
    logic                     start;
    logic [COL_W-1:0]         col;
    logic signed [ACC_W-1:0]  acc;
    logic                     fail;
    logic [ACC_W-1:0]         run_max;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    abs_sum;
    logic signed [ACC_W-1:0]    diff;
    logic [ACC_W-1:0]           err;

    assign start = (state == IDLE) && bus.en_error && !en_prev;

    always_ff @(posedge clk_error) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = COMPARE;
            COMPARE: if (bus.rd_addr == LAST_ADDR) next_state = DRAIN;
            DRAIN:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Width rules guarantee no overflow, so plain two's-complement abs is safe.
    assign prod     = $signed(bus.w_new_data) * $signed(bus.w_old_data);
    assign prod_ext = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
    assign sum      = acc + prod_ext;
    assign abs_sum  = sum[ACC_W-1] ? -sum : sum;
    assign diff     = ONE - abs_sum;
    assign err      = diff[ACC_W-1] ? ACC_W'(-diff) : ACC_W'(diff);

    // The store write mirrors the read data in the cycle it returns.
    assign bus.old_wr_data = bus.old_wr_en ? bus.w_new_data : '0;

    always_ff @(posedge clk_error) begin
        if (!rstn) begin
            en_prev         <= 1'b0;
            bus.error_busy  <= 1'b0;
            bus.isConverge  <= 1'b0;
            bus.rd_en       <= 1'b0;
            bus.rd_addr     <= '0;
            bus.old_wr_en   <= 1'b0;
            bus.old_wr_addr <= '0;
            bus.err_max     <= '0;
            col             <= '0;
            acc             <= '0;
            fail            <= 1'b0;
            run_max         <= '0;
        end else begin
            en_prev         <= bus.en_error;
            bus.old_wr_en   <= bus.rd_en;
            bus.old_wr_addr <= bus.rd_addr;

            if (bus.old_wr_en) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    acc <= '0;
                    if (err > EPS_V)   fail    <= 1'b1;
                    if (err > run_max) run_max <= err;
                end else begin
                    col <= col + COL_W'(1);
                    acc <= sum;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        bus.error_busy <= 1'b1;
                        bus.isConverge <= 1'b0;
                        bus.rd_en      <= 1'b1;
                        bus.rd_addr    <= '0;
                        col            <= '0;
                        acc            <= '0;
                    end
                end
                COMPARE: begin
                    if (bus.rd_addr == LAST_ADDR) begin
                        bus.rd_en   <= 1'b0;
                        bus.rd_addr <= '0;
                    end else begin
                        bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
                    end
                end
                DONE: begin
                    bus.error_busy <= 1'b0;
                    bus.isConverge <= ~fail;
                    bus.err_max    <= run_max;
                    fail           <= 1'b0;
                    run_max        <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fastica_error_unit.sv
// tb/tb_fastica_error_unit.sv - scoreboard bench for fastica_error_unit
module tb_fastica_error_unit;
    localparam int N  = 4;
    localparam int NN = N * N;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    fastica_error_unit_if #(.DATA_W(16), .ADDR_W(4), .ACC_W(34)) bus ();

    fastica_error_unit #(
        .N(4), .DATA_W(16), .FRAC(14), .ADDR_W(4), .ACC_W(34), .EPS(268)
    ) dut (
        .clk_error(clk),
        .rstn(rstn),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    logic signed [15:0] new_m [NN];
    logic signed [15:0] old_m [NN];

    // Weight stores: 1-cycle read latency, old store written by the DUT.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.w_new_data <= new_m[bus.rd_addr];
            bus.w_old_data <= old_m[bus.rd_addr];
        end
        if (bus.old_wr_en) old_m[bus.old_wr_addr] = bus.old_wr_data;
    end

    typedef struct packed {
        logic         conv;
        logic [33:0]  emax;
        logic [255:0] old_img;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   runs_done = 0;

    task automatic check(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t model();
        exp_t   e;
        longint dot, err, mx;
        bit     ok;
        mx = 0;
        ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            dot = 0;
            for (int j = 0; j < N; j++)
                dot += longint'(new_m[i*N+j]) * longint'(old_m[i*N+j]);
            if (dot < 0) dot = -dot;
            err = (longint'(1) << 28) - dot;
            if (err < 0) err = -err;
            if (err > 268) ok = 1'b0;
            if (err > mx) mx = err;
        end
        e.conv = ok;
        e.emax = 34'(mx);
        for (int k = 0; k < NN; k++) e.old_img[k*16 +: 16] = new_m[k];
        return e;
    endfunction

    logic [255:0] img_now;
    exp_t         e_pop;

    initial begin : monitor
        int blen, rcnt, wcnt;
        bit prev_busy, conv_seen, addr_bad, data_bad;
        blen = 0; rcnt = 0; wcnt = 0;
        prev_busy = 0; conv_seen = 0; addr_bad = 0; data_bad = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                blen = 0; rcnt = 0; wcnt = 0;
                prev_busy = 0; conv_seen = 0; addr_bad = 0; data_bad = 0;
            end else begin
                if (bus.error_busy) begin
                    blen++;
                    if (bus.isConverge) conv_seen = 1;
                end
                if (bus.rd_en) rcnt++;
                if (bus.old_wr_en) begin
                    if (int'(bus.old_wr_addr) != wcnt) addr_bad = 1;
                    if (bus.old_wr_data != new_m[bus.old_wr_addr]) data_bad = 1;
                    wcnt++;
                end
                if (prev_busy && !bus.error_busy) begin
                    runs_done++;
                    check("busy_len", blen, NN + 2);
                    check("rd_count", rcnt, NN);
                    check("wr_count", wcnt, NN);
                    check("wr_addr_order", addr_bad, 0);
                    check("wr_data", data_bad, 0);
                    check("conv_while_busy", conv_seen, 0);
                    check("sb_has_entry", longint'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e_pop = sb.pop_front();
                        for (int k = 0; k < NN; k++) img_now[k*16 +: 16] = old_m[k];
                        check("isConverge", bus.isConverge, e_pop.conv);
                        check("err_max", bus.err_max, e_pop.emax);
                        check("old_store", longint'(img_now == e_pop.old_img), 1);
                    end
                    blen = 0; rcnt = 0; wcnt = 0;
                    conv_seen = 0; addr_bad = 0; data_bad = 0;
                end
                prev_busy = bus.error_busy;
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(int r0);
        int t = 0;
        while (runs_done == r0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("run_timeout", longint'(t < 60), 1);
    endtask

    task automatic pulse_run();
        int r0 = runs_done;
        sb.push_back(model());
        bus.en_error = 1'b1;
        cyc(1);
        bus.en_error = 1'b0;
        wait_done(r0);
        cyc(1);
    endtask

    task automatic set_identity();
        for (int k = 0; k < NN; k++) begin
            new_m[k] = (k % (N + 1) == 0) ? 16'sd16384 : 16'sd0;
            old_m[k] = new_m[k];
        end
    endtask

    task automatic randomize_mats(int mode);
        int c, a, b;
        set_identity();
        if (mode == 0) begin
            for (int k = 0; k < NN; k++) begin
                new_m[k] = 16'($urandom);
                old_m[k] = 16'($urandom);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                c = (i + 1 + int'($urandom_range(0, N - 2))) % N;
                a = int'($urandom_range(0, 20));
                b = int'($urandom_range(0, 20));
                new_m[i*N+c] = 16'(a);
                old_m[i*N+c] = 16'(b);
                if ($urandom_range(0, 1) == 1) new_m[i*N+i] = -16'sd16384;
            end
        end
    endtask

    task automatic check_outputs_zero();
        check("rst_error_busy", bus.error_busy, 0);
        check("rst_isConverge", bus.isConverge, 0);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_old_wr_en", bus.old_wr_en, 0);
        check("rst_old_wr_addr", bus.old_wr_addr, 0);
        check("rst_old_wr_data", bus.old_wr_data, 0);
        check("rst_err_max", bus.err_max, 0);
    endtask

    initial begin : stimulus
        int r0, act;
        bus.en_error = 1'b0;
        set_identity();
        rstn = 1'b0;
        cyc(3);
        check_outputs_zero();
        rstn = 1'b1;
        cyc(2);

        set_identity();
        pulse_run();

        set_identity();
        new_m[2*N+2] = -16'sd16384;
        pulse_run();

        set_identity();
        new_m[0] = 16'sd16000;
        pulse_run();

        set_identity();
        new_m[1] = 16'sd4;
        old_m[1] = 16'sd67;
        pulse_run();

        set_identity();
        new_m[1] = 16'sd1;
        old_m[1] = 16'sd269;
        pulse_run();

        for (int k = 0; k < NN; k++) begin
            new_m[k] = -16'sd32768;
            old_m[k] = -16'sd32768;
        end
        pulse_run();

        for (int t = 0; t < 16; t++) begin
            randomize_mats(int'($urandom_range(0, 2)));
            pulse_run();
        end

        randomize_mats(0);
        r0 = runs_done;
        sb.push_back(model());
        bus.en_error = 1'b1;
        wait_done(r0);
        cyc(10);
        check("hold_single_run", runs_done - r0, 1);
        check("hold_no_retrigger", bus.error_busy, 0);
        bus.en_error = 1'b0;
        cyc(1);
        pulse_run();

        randomize_mats(0);
        r0 = runs_done;
        sb.push_back(model());
        bus.en_error = 1'b1;
        cyc(3);
        bus.en_error = 1'b0;
        wait_done(r0);
        cyc(1);

        randomize_mats(0);
        bus.en_error = 1'b1;
        cyc(1);
        bus.en_error = 1'b0;
        cyc(4);
        rstn = 1'b0;
        cyc(1);
        check_outputs_zero();
        rstn = 1'b1;
        act = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            if (bus.rd_en || bus.old_wr_en || bus.error_busy) act++;
        end
        check("no_activity_after_reset", act, 0);
        pulse_run();

        cyc(3);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
